// File: rtl/btb_nway_cache.sv
// N-way set-associative branch target buffer with a registered lookup, in-place update,
// round-robin replacement, targeted invalidate and a sequential whole-array flush.
module btb_nway_cache #(
    parameter int SETS = 512,
    parameter int WAYS = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        rd_req,
    input  logic [31:0] rd_pc,
    output logic        rd_valid,
    output logic        rd_hit,
    output logic [31:0] rd_target,
    input  logic        wr_req,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target,
    input  logic        inv_req,
    input  logic [31:0] inv_pc,
    input  logic        flush_req,
    output logic        busy
);
    // state    | meaning
    // ST_IDLE  | normal lookup / write / invalidate
    // ST_FLUSH | clearing set flush_idx each cycle; reads miss, updates dropped
    localparam int INDEX_W = $clog2(SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W   = 30 - INDEX_W;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
    state_t state, state_nxt;
    logic [INDEX_W-1:0] flush_idx;

    logic [WAYS-1:0]  valid    [SETS];
    logic [WAY_W-1:0] rr_ptr   [SETS];
    logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
    logic [31:0]      data_mem [SETS][WAYS];

    logic [INDEX_W-1:0] rd_idx, wr_idx, inv_idx;
    logic [TAG_W-1:0]   rd_tag, wr_tag, inv_tag;
    logic               unused_pc_bits;

    assign rd_idx  = rd_pc[INDEX_W+1:2];
    assign wr_idx  = wr_pc[INDEX_W+1:2];
    assign inv_idx = inv_pc[INDEX_W+1:2];
    assign rd_tag  = rd_pc[31:INDEX_W+2];
    assign wr_tag  = wr_pc[31:INDEX_W+2];
    assign inv_tag = inv_pc[31:INDEX_W+2];
    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0], inv_pc[1:0]};

    logic             lk_hit, wr_match, wr_free, inv_hit, wr_bump, wr_en, inv_en;
    logic [WAY_W-1:0] lk_way, wr_match_way, wr_free_way, wr_way, inv_way, rr_nxt;

    // Descending scans so the lowest matching way is the one left selected.
    always_comb begin
        lk_hit       = 1'b0;
        lk_way       = '0;
        wr_match     = 1'b0;
        wr_match_way = '0;
        wr_free      = 1'b0;
        wr_free_way  = '0;
        inv_hit      = 1'b0;
        inv_way      = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[rd_idx][w] && tag_mem[rd_idx][w] == rd_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (valid[wr_idx][w] && tag_mem[wr_idx][w] == wr_tag) begin
                wr_match     = 1'b1;
                wr_match_way = WAY_W'(w);
            end
            if (!valid[wr_idx][w]) begin
                wr_free     = 1'b1;
                wr_free_way = WAY_W'(w);
            end
            if (valid[inv_idx][w] && tag_mem[inv_idx][w] == inv_tag) begin
                inv_hit = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign wr_way  = wr_match ? wr_match_way : (wr_free ? wr_free_way : rr_ptr[wr_idx]);
    assign wr_bump = !wr_match && !wr_free;
    assign rr_nxt  = (rr_ptr[wr_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[wr_idx] + 1'b1;
    assign wr_en   = wr_req  && state == ST_IDLE && !flush_req;
    assign inv_en  = inv_req && state == ST_IDLE && !flush_req;
    assign busy    = (state == ST_FLUSH);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (flush_req) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_idx == INDEX_W'(SETS - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            flush_idx <= '0;
        end else begin
            state     <= state_nxt;
            flush_idx <= (state == ST_FLUSH) ? flush_idx + 1'b1 : '0;
        end
    end

    // Invalidate is applied before the write so a same-entry write ends valid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else if (state == ST_FLUSH) begin
            valid[flush_idx]  <= '0;
            rr_ptr[flush_idx] <= '0;
        end else begin
            if (inv_en && inv_hit) valid[inv_idx][inv_way] <= 1'b0;
            if (wr_en) begin
                valid[wr_idx][wr_way] <= 1'b1;
                if (wr_bump) rr_ptr[wr_idx] <= rr_nxt;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[wr_idx][wr_way]  <= wr_tag;
            data_mem[wr_idx][wr_way] <= wr_target;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_valid  <= 1'b0;
            rd_hit    <= 1'b0;
            rd_target <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req && state == ST_IDLE && lk_hit) begin
                rd_hit    <= 1'b1;
                rd_target <= data_mem[rd_idx][lk_way];
            end else begin
                rd_hit    <= 1'b0;
                rd_target <= '0;
            end
        end
    end
endmodule

// File: tb/tb_btb_nway_cache.sv
// Scoreboard bench for btb_nway_cache: a set/way reference model predicts each lookup
// response and the busy flag; a negedge monitor pops and compares responses.
module tb_btb_nway_cache;
    localparam int SETS = 512;
    localparam int WAYS = 2;
    localparam int IW   = $clog2(SETS);

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        rd_req = 1'b0, wr_req = 1'b0, inv_req = 1'b0, flush_req = 1'b0;
    logic [31:0] rd_pc = '0, wr_pc = '0, wr_target = '0, inv_pc = '0;
    logic        rd_valid, rd_hit, busy;
    logic [31:0] rd_target;

    always #5 CLK = ~CLK;

    btb_nway_cache #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CLK(CLK), .RESET(RESET),
        .rd_req(rd_req), .rd_pc(rd_pc), .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_target(rd_target),
        .wr_req(wr_req), .wr_pc(wr_pc), .wr_target(wr_target),
        .inv_req(inv_req), .inv_pc(inv_pc), .flush_req(flush_req), .busy(busy)
    );

    typedef struct {
        bit          hit;
        logic [31:0] tgt;
    } resp_t;

    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int          m_rr    [SETS];
    int          busy_left = 0;
    resp_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return int'(pc >> (IW + 2));
    endfunction

    function automatic int find_way(int s, int unsigned t);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    // Applies one clock edge's worth of the rules to the model, using the pre-edge inputs.
    task automatic model_step();
        resp_t r;
        bit    busy_now;
        int    s, ws, wi;
        busy_now = (busy_left > 0);
        if (rd_req) begin
            r.hit = 1'b0;
            r.tgt = '0;
            if (!busy_now) begin
                ws = find_way(idx_of(rd_pc), tag_of(rd_pc));
                if (ws >= 0) begin
                    r.hit = 1'b1;
                    r.tgt = m_data[idx_of(rd_pc)][ws];
                end
            end
            exp_q.push_back(r);
        end
        if (busy_now) begin
            busy_left--;
        end else if (flush_req) begin
            model_clear();
            busy_left = SETS;
        end else begin
            ws = -1;
            s  = idx_of(wr_pc);
            if (wr_req) begin
                ws = find_way(s, tag_of(wr_pc));
                if (ws < 0)
                    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) ws = w;
                if (ws < 0) begin
                    ws = m_rr[s];
                    m_rr[s] = (m_rr[s] + 1) % WAYS;
                end
            end
            if (inv_req) begin
                wi = find_way(idx_of(inv_pc), tag_of(inv_pc));
                if (wi >= 0) m_valid[idx_of(inv_pc)][wi] = 1'b0;
            end
            if (wr_req) begin
                m_valid[s][ws] = 1'b1;
                m_tag[s][ws]   = tag_of(wr_pc);
                m_data[s][ws]  = wr_target;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        tests++;
        if (busy !== (busy_left > 0)) begin
            fails++;
            $display("FAIL busy: got %0b expected %0b at %0t", busy, busy_left > 0, $time);
        end
    endtask

    task automatic idle();
        rd_req = 1'b0; wr_req = 1'b0; inv_req = 1'b0; flush_req = 1'b0;
    endtask

    task automatic op(bit rd, logic [31:0] rpc, bit wr, logic [31:0] wpc, logic [31:0] tgt,
                      bit inv, logic [31:0] ipc, bit fl);
        rd_req = rd; rd_pc = rpc; wr_req = wr; wr_pc = wpc; wr_target = tgt;
        inv_req = inv; inv_pc = ipc; flush_req = fl;
        cycle();
        idle();
    endtask

    task automatic rd(logic [31:0] pc);
        op(1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(logic [31:0] pc, logic [31:0] tgt);
        op(0, 0, 1, pc, tgt, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = 32'($urandom_range(1, 6)) << (IW + 2);
        p = p | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        return p;
    endfunction

    task automatic rand_cycle(bit allow_flush);
        op($urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 2) == 0, rand_pc(), $urandom,
           $urandom_range(0, 5) == 0, rand_pc(), allow_flush && $urandom_range(0, 299) == 0);
    endtask

    task automatic read_pool();
        for (int t = 1; t <= 6; t++)
            for (int i = 0; i < 4; i++) rd((32'(t) << (IW + 2)) | (32'(i) << 2));
    endtask

    task automatic check_reset_outputs(string tag);
        tests++;
        if (rd_valid !== 1'b0 || rd_hit !== 1'b0 || rd_target !== 32'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: got valid=%0b hit=%0b tgt=%h busy=%0b expected all zero",
                     tag, rd_valid, rd_hit, rd_target, busy);
        end
    endtask

    always @(negedge CLK) begin
        resp_t r;
        if (RESET) begin
            if (rd_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_rd_valid: got rd_valid=1 expected 0 at %0t", $time);
                end else begin
                    r = exp_q.pop_front();
                    if (rd_hit !== r.hit || rd_target !== r.tgt) begin
                        fails++;
                        $display("FAIL lookup: got hit=%0b tgt=%h expected hit=%0b tgt=%h at %0t",
                                 rd_hit, rd_target, r.hit, r.tgt, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL missing_rd_valid: got rd_valid=0 expected 1 at %0t", $time);
                exp_q.delete();
            end
        end
    end

    initial begin
        model_clear();
        #2;
        check_reset_outputs("reset_state");
        #10 RESET = 1'b1;

        rd(32'h0000_1000);
        wr(32'h0000_1000, 32'h0000_2000);
        rd(32'h0000_1000);
        op(1, 32'h0000_1004, 1, 32'h0000_1004, 32'h0000_5555, 0, 0, 0);
        rd(32'h0000_1004);

        wr(32'h0000_1800, 32'hBBBB_0000);
        wr(32'h0000_2000, 32'hCCCC_0000);
        rd(32'h0000_1000);
        rd(32'h0000_1800);
        rd(32'h0000_2000);

        wr(32'h0000_1800, 32'hDDDD_0000);
        rd(32'h0000_1800);
        rd(32'h0000_2000);
        wr(32'h0000_2800, 32'hFFFF_0000);
        rd(32'h0000_1800);
        rd(32'h0000_2000);
        rd(32'h0000_2800);

        op(0, 0, 0, 0, 0, 1, 32'h0000_2000, 0);
        rd(32'h0000_2000);
        op(0, 0, 1, 32'h0000_1800, 32'hEEEE_0000, 1, 32'h0000_1800, 0);
        rd(32'h0000_1800);
        op(0, 0, 1, 32'h0000_3000, 32'h1234_5678, 1, 32'h0000_2800, 0);
        rd(32'h0000_2800);
        rd(32'h0000_3000);

        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        for (int i = 0; i < SETS + 4; i++) rand_cycle(1'b0);

        for (int i = 0; i < 60; i++) rand_cycle(1'b0);
        op(0, 0, 1, 32'h0000_1000, 32'hAAAA_0000, 1, 32'h0000_1800, 1);
        for (int i = 0; i < SETS + 2; i++) rand_cycle(1'b1);
        read_pool();

        for (int i = 0; i < 60; i++) rand_cycle(1'b0);
        op(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 99; i++) rand_cycle(1'b1);
        rd_req = 1'b1; rd_pc = 32'h0000_1000;
        cycle();
        idle();
        RESET = 1'b0;
        exp_q.delete();
        model_clear();
        busy_left = 0;
        #1;
        check_reset_outputs("reset_mid_flush");
        #20 RESET = 1'b1;
        read_pool();
        for (int i = 0; i < 500; i++) rand_cycle(1'b1);
        for (int i = 0; i < SETS + 4; i++) rand_cycle(1'b0);
        idle();
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
